divisor_sec: RTL and testbench

Sequential unsigned restoring divider: control FSM and datapath for SIZE-bit dividend/divisor, one quotient bit per two-cycle shift/subtract iteration. It is the inverse operation of the team's sequential Booth multiplier and uses the same shift-and-operate style. A start/Fin handshake exposes the result, which is held stable between operations.

---
 rtl/divisor_sec.sv | 129 ++++++++++++
 tb/tb_divisor_sec.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/divisor_sec.sv
// divisor_sec: sequential unsigned restoring divider.
// Each quotient bit takes one SHIFT/SUB pair. Results are held in output registers between operations.
module divisor_sec #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            busy,
    output logic            div_zero,
    output logic            Fin
);
    // state | meaning
    // IDLE  | waiting for start; results held
    // LOAD  | clear partial remainder and iteration counter
    // SHIFT | shift {R,Q} left one bit
    // SUB   | trial subtract, decide quotient bit
    // DONE  | one-cycle Fin pulse, results valid
    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE:0]   r_q, r_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [SIZE-1:0] m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] quot_q, quot_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic            dz_q, dz_d;
    logic [SIZE+1:0] diff;

    // Extra top bit makes the sign of the trial subtraction explicit.
    assign diff = {1'b0, r_q} - {2'b00, m_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        m_d     = divisor;
                        q_d     = dividend;
                    end
                end
            end
            S_LOAD: begin
                r_d     = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                r_d     = {r_q[SIZE-1:0], q_q[SIZE-1]};
                q_d     = {q_q[SIZE-2:0], 1'b0};
                state_d = S_SUB;
            end
            S_SUB: begin
                if (!diff[SIZE+1]) begin
                    r_d = diff[SIZE:0];
                end
                q_d   = {q_q[SIZE-1:1], ~diff[SIZE+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[SIZE-1:0];
                    dz_d    = 1'b0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_SUB);
    assign Fin       = (state_q == S_DONE);

endmodule

// File: tb/tb_divisor_sec.sv
// Directed bench for divisor_sec (SIZE=4).
// Covers timing, holding, divide-by-zero, back-to-back, mid-op reset and an exhaustive sweep.
module tb_divisor_sec;
    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       div_zero;
    logic       Fin;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int fin_cnt;
    int last_fin;
    int fin_seen;

    always #5 clk = ~clk;

    divisor_sec #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .div_zero  (div_zero),
        .Fin       (Fin)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at #1 after a clock edge with the DUT in IDLE.
    task automatic run_div(input string tag, input int a, input int b, output int l);
        int busy_cnt;
        int held_bad;
        logic [3:0] pq, pr;
        logic pz;
        busy_cnt = 0;
        held_bad = 0;
        pq = quotient;
        pr = remainder;
        pz = div_zero;
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        tick();
        start = 1'b0;
        l = 0;
        while (!Fin && l < 40) begin
            busy_cnt += int'(busy);
            if (quotient !== pq || remainder !== pr || div_zero !== pz) held_bad++;
            tick();
            l++;
        end
        chk({tag, " latency"}, l, (b == 0) ? 0 : 2 * SIZE + 1);
        chk({tag, " busy cycles"}, busy_cnt, (b == 0) ? 0 : 2 * SIZE + 1);
        chk({tag, " held"}, held_bad, 0);
        chk({tag, " busy@Fin"}, int'(busy), 0);
        if (b == 0) begin
            chk({tag, " quotient"}, int'(quotient), 15);
            chk({tag, " remainder"}, int'(remainder), a);
            chk({tag, " div_zero"}, int'(div_zero), 1);
        end else begin
            chk({tag, " quotient"}, int'(quotient), a / b);
            chk({tag, " remainder"}, int'(remainder), a % b);
            chk({tag, " div_zero"}, int'(div_zero), 0);
        end
        tick();
        chk({tag, " Fin width"}, int'(Fin), 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset div_zero", int'(div_zero), 0);
        chk("reset Fin", int'(Fin), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        run_div("13/3", 13, 3, lat);
        run_div("15/1", 15, 1, lat);
        run_div("5/7", 5, 7, lat);
        run_div("9/0", 9, 0, lat);
        run_div("8/2", 8, 2, lat);

        // Back-to-back with start held; operands scrambled whenever busy.
        fin_cnt  = 0;
        last_fin = -1;
        dividend = 4'd14;
        divisor  = 4'd5;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            tick();
            if (Fin) begin
                chk("b2b quotient", int'(quotient), 2);
                chk("b2b remainder", int'(remainder), 4);
                chk("b2b div_zero", int'(div_zero), 0);
                if (last_fin >= 0) chk("b2b period", cyc - last_fin, 11);
                last_fin = cyc;
                fin_cnt++;
            end
            if (busy) begin
                dividend = 4'd15;
                divisor  = 4'd1;
            end else begin
                dividend = 4'd14;
                divisor  = 4'd5;
            end
        end
        start = 1'b0;
        chk("b2b Fin count", fin_cnt, 3);
        lat = 0;
        while (!Fin && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b drain Fin", int'(Fin), 1);
        chk("b2b drain quotient", int'(quotient), 2);
        chk("b2b drain remainder", int'(remainder), 4);
        tick();

        // Leave a non-zero result so the reset clearing is visible.
        run_div("3/0", 3, 0, lat);
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst quotient", int'(quotient), 0);
        chk("midrst remainder", int'(remainder), 0);
        chk("midrst div_zero", int'(div_zero), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst Fin", int'(Fin), 0);
        tick();
        tick();
        reset_n  = 1'b1;
        fin_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Fin) fin_seen++;
        end
        chk("midrst no Fin", fin_seen, 0);
        chk("midrst quotient after", int'(quotient), 0);
        run_div("12/5 after reset", 12, 5, lat);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div($sformatf("sweep %0d/%0d", a, b), a, b, lat);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
